// File: rtl/acumulador_ventana_pkg.sv
// Shared types, default widths and the sign-extension helper for the lock-in
// window accumulator.
package lockin_pkg;

    localparam int IN_W_DEF  = 64;
    localparam int CNT_W_DEF = 16;
    localparam int ACC_W_DEF = 80;

    typedef enum logic {
        IDLE = 1'b0,
        ACUM = 1'b1
    } estado_t;

    function automatic logic signed [ACC_W_DEF-1:0] sext(input logic signed [IN_W_DEF-1:0] x);
        return ACC_W_DEF'(x);
    endfunction

endpackage

// File: rtl/acumulador_ventana_if.sv
// Control, sample stream and result bundle of the window accumulator.
// master drives controls and samples; slave is the accumulator itself.
interface acumulador_ventana_if
    import lockin_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) ();

    logic                    enable;
    logic                    start;
    logic                    stop;
    logic                    continuo;
    logic [CNT_W-1:0]        ciclos;
    logic signed [IN_W-1:0]  data_in;
    logic                    data_valid;
    logic signed [ACC_W-1:0] data_out;
    logic                    data_out_valid;
    logic                    busy;
    logic [CNT_W-1:0]        ventanas;

    modport master (
        output enable, start, stop, continuo, ciclos, data_in, data_valid,
        input  data_out, data_out_valid, busy, ventanas
    );

    modport slave (
        input  enable, start, stop, continuo, ciclos, data_in, data_valid,
        output data_out, data_out_valid, busy, ventanas
    );

endinterface

// File: rtl/acumulador_ventana_contador.sv
// Window sample counter: latches N on load, counts accepted samples and flags
// the sample that closes the window (fin is combinational on the current count).
module contador_ventana #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] n_in,
    output logic             fin
);

    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        n_d   = n_q;
        cnt_d = cnt_q;
        if (load) begin
            n_d   = n_in;
            cnt_d = '0;
        end else if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            n_q   <= '0;
            cnt_q <= '0;
        end else begin
            n_q   <= n_d;
            cnt_q <= cnt_d;
        end
    end

    // Only meaningful while a window is armed, where N is never zero.
    assign fin = (cnt_q == (n_q - CNT_W'(1)));

endmodule

// File: rtl/acumulador_ventana.sv
// Integrates N accepted lock-in products per window and emits the exact sum as a
// one-cycle pulse one clock after the closing sample; one-shot or continuous, abortable.
module acumulador_ventana
    import lockin_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    acumulador_ventana_if.slave bus
);

    if (ACC_W < IN_W + CNT_W) begin : g_ancho_invalido
        $error("acumulador_ventana: ACC_W must be >= IN_W + CNT_W");
    end

    logic signed [ACC_W-1:0] din_ext;

    if (IN_W == IN_W_DEF && ACC_W == ACC_W_DEF) begin : g_sext_def
        assign din_ext = sext(bus.data_in);
    end else begin : g_sext_gen
        assign din_ext = ACC_W'(bus.data_in);
    end

    estado_t                 estado_q, estado_d;
    logic signed [ACC_W-1:0] suma_q, suma_d;
    logic signed [ACC_W-1:0] data_out_q, data_out_d;
    logic                    data_out_valid_q, data_out_valid_d;
    logic                    busy_q, busy_d;
    logic [CNT_W-1:0]        ventanas_q, ventanas_d;
    logic                    continuo_q, continuo_d;

    logic cnt_load, cnt_clear, cnt_inc, fin;
    logic acepta;

    contador_ventana #(.CNT_W(CNT_W)) u_contador (
        .clock (clock),
        .reset (reset),
        .load  (cnt_load),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .n_in  (bus.ciclos),
        .fin   (fin)
    );

    // stop outranks a coincident sample, even one that would close the window.
    assign acepta = (estado_q == ACUM) && bus.enable && bus.data_valid && !bus.stop;

    always_comb begin
        estado_d         = estado_q;
        suma_d           = suma_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        busy_d           = busy_q;
        ventanas_d       = ventanas_q;
        continuo_d       = continuo_q;
        cnt_load         = 1'b0;
        cnt_clear        = 1'b0;
        cnt_inc          = 1'b0;

        case (estado_q)
            IDLE: begin
                if (bus.start && (bus.ciclos != '0)) begin
                    estado_d   = ACUM;
                    busy_d     = 1'b1;
                    suma_d     = '0;
                    ventanas_d = '0;
                    continuo_d = bus.continuo;
                    cnt_load   = 1'b1;
                end
            end
            ACUM: begin
                if (bus.stop) begin
                    estado_d  = IDLE;
                    busy_d    = 1'b0;
                    suma_d    = '0;
                    cnt_clear = 1'b1;
                end else if (acepta) begin
                    if (fin) begin
                        data_out_d       = suma_q + din_ext;
                        data_out_valid_d = 1'b1;
                        ventanas_d       = ventanas_q + CNT_W'(1);
                        suma_d           = '0;
                        cnt_clear        = 1'b1;
                        if (!continuo_q) begin
                            estado_d = IDLE;
                            busy_d   = 1'b0;
                        end
                    end else begin
                        suma_d  = suma_q + din_ext;
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                estado_d = IDLE;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q         <= IDLE;
            suma_q           <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            busy_q           <= 1'b0;
            ventanas_q       <= '0;
            continuo_q       <= 1'b0;
        end else begin
            estado_q         <= estado_d;
            suma_q           <= suma_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            busy_q           <= busy_d;
            ventanas_q       <= ventanas_d;
            continuo_q       <= continuo_d;
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = data_out_valid_q;
    assign bus.busy           = busy_q;
    assign bus.ventanas       = ventanas_q;

endmodule

// File: tb/tb_acumulador_ventana.sv
// Randomized and directed bench for acumulador_ventana with a queue-based reference model.
module tb_acumulador_ventana;
    import lockin_pkg::*;

    localparam int IN_W  = 64;
    localparam int CNT_W = 16;
    localparam int ACC_W = 80;

    typedef struct {
        logic signed [ACC_W-1:0] sum;
        logic [CNT_W-1:0]        vent;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    acumulador_ventana_if #(.IN_W(IN_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();

    acumulador_ventana #(.IN_W(IN_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;
    bit mon_on = 1'b0;

    // Reference model state: samples of the open window kept as a plain list.
    bit                      m_acum = 1'b0;
    int                      m_n    = 0;
    bit                      m_cont = 1'b0;
    logic signed [IN_W-1:0]  m_win[$];
    logic [CNT_W-1:0]        m_vent = '0;
    logic signed [ACC_W-1:0] m_last = '0;
    exp_t                    exp_q[$];

    logic signed [ACC_W-1:0] last_pulse = '0;
    int                      pulse_cnt  = 0;

    task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step();
        logic signed [ACC_W-1:0] s;
        if (reset) begin
            m_acum = 1'b0;
            m_win.delete();
            m_vent = '0;
            m_last = '0;
            exp_q.delete();
        end else if (!m_acum) begin
            if (bus.start && bus.ciclos != 0) begin
                m_acum = 1'b1;
                m_n    = int'(bus.ciclos);
                m_cont = bus.continuo;
                m_win.delete();
                m_vent = '0;
            end
        end else if (bus.stop) begin
            m_acum = 1'b0;
            m_win.delete();
        end else if (bus.enable && bus.data_valid) begin
            m_win.push_back(bus.data_in);
            if (m_win.size() == m_n) begin
                s = '0;
                foreach (m_win[i]) s = s + m_win[i];
                m_vent = m_vent + 1'b1;
                m_last = s;
                exp_q.push_back('{sum: s, vent: m_vent});
                m_win.delete();
                if (!m_cont) m_acum = 1'b0;
            end
        end
    endtask

    task automatic cyc(input bit en, input bit dv, input logic signed [IN_W-1:0] d,
                       input bit st = 1'b0, input bit sp = 1'b0,
                       input logic [CNT_W-1:0] n = '0, input bit c = 1'b0);
        bus.enable     = en;
        bus.data_valid = dv;
        bus.data_in    = d;
        bus.start      = st;
        bus.stop       = sp;
        bus.ciclos     = n;
        bus.continuo   = c;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, '0);
    endtask

    // Monitor: every cycle the outputs must match the model, and each pulse pops one expectation.
    always @(negedge clock) begin
        if (mon_on) begin
            if (bus.data_out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_data_out", bus.data_out, e.sum);
                    chk("pulse_ventanas", ACC_W'(bus.ventanas), ACC_W'(e.vent));
                end
                last_pulse = bus.data_out;
                pulse_cnt++;
            end
            chk("pending_pulses", ACC_W'(exp_q.size()), '0);
            chk("busy", ACC_W'(bus.busy), ACC_W'(m_acum));
            chk("data_out_hold", bus.data_out, m_last);
            chk("ventanas", ACC_W'(bus.ventanas), ACC_W'(m_vent));
        end
    end

    initial begin
        int p0;
        logic signed [ACC_W-1:0] big_exp;
        logic signed [IN_W-1:0]  minv;
        logic signed [IN_W-1:0]  rnd;

        bus.enable = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.continuo = 1'b0;
        bus.ciclos = '0; bus.data_in = '0; bus.data_valid = 1'b0;
        reset = 1'b1;
        cyc(1'b0, 1'b0, '0);
        mon_on = 1'b1;
        cyc(1'b0, 1'b0, '0);
        chk("reset_data_out_valid", ACC_W'(bus.data_out_valid), '0);
        reset = 1'b0;
        idle(2);

        // One-shot N=4.
        p0 = pulse_cnt;
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'd4, 1'b0);
        cyc(1, 1, 10); cyc(1, 1, -3); cyc(1, 1, 7); cyc(1, 1, 1);
        idle(2);
        chk("n4_sum", last_pulse, 80'sd15);
        chk("n4_pulses", ACC_W'(pulse_cnt - p0), 80'd1);

        // Continuous N=2, back-to-back.
        p0 = pulse_cnt;
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'd2, 1'b1);
        cyc(1, 1, 5); cyc(1, 1, 5); cyc(1, 1, -8); cyc(1, 1, 2); cyc(1, 1, 100); cyc(1, 1, 1);
        idle(1);
        chk("cont_last_sum", last_pulse, 80'sd101);
        chk("cont_pulses", ACC_W'(pulse_cnt - p0), 80'd3);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        idle(1);

        // enable low drops a sample.
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'd3, 1'b0);
        cyc(1, 1, 1); cyc(1, 1, 2); cyc(0, 1, 3); cyc(1, 1, 4);
        idle(2);
        chk("enable_drop_sum", last_pulse, 80'sd7);

        // stop beats a coincident sample; then N=1 with -1.
        p0 = pulse_cnt;
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'd3, 1'b0);
        cyc(1, 1, 1); cyc(1, 1, 2);
        cyc(1'b1, 1'b1, 64'sd9, 1'b0, 1'b1);
        idle(2);
        chk("stop_no_pulse", ACC_W'(pulse_cnt - p0), '0);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'd1, 1'b0);
        cyc(1, 1, -1);
        idle(2);
        chk("n1_minus_one", last_pulse, {ACC_W{1'b1}});

        // start with zero length, and start during ACUM.
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'd0, 1'b0);
        idle(2);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'd2, 1'b0);
        cyc(1, 1, 3);
        cyc(1'b1, 1'b1, 64'sd4, 1'b1, 1'b0, 16'd5, 1'b1);
        idle(2);
        chk("start_in_acum_sum", last_pulse, 80'sd7);

        // Full-scale negative over the longest window.
        minv = '0;
        minv[IN_W-1] = 1'b1;
        big_exp = 80'd0 - (80'd65535 << 63);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'hFFFF, 1'b0);
        for (int i = 0; i < 65535; i++) cyc(1, 1, minv);
        idle(2);
        chk("fullscale_sum", last_pulse, big_exp);

        // Reset in the middle of a repeat run.
        p0 = pulse_cnt;
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'hFFFF, 1'b0);
        for (int i = 0; i < 100; i++) cyc(1, 1, minv);
        reset = 1'b1;
        cyc(1, 1, minv);
        reset = 1'b0;
        idle(3);
        chk("reset_mid_no_pulse", ACC_W'(pulse_cnt - p0), '0);
        chk("reset_mid_data_out", bus.data_out, '0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rnd = IN_W'($signed($urandom_range(0, 40)) - 20);
            cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), rnd,
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
                CNT_W'($urandom_range(0, 6)), $urandom_range(0, 1) == 1);
        end
        idle(3);

        mon_on = 1'b0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
